// File: rtl/keypad_pkg.sv
// Shared constants for the keypad entry path: debounce FSM encodings, editing key codes
// and the active-low seven-segment font.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CAND = 2'd1;
  localparam state_t HELD = 2'd2;
  localparam state_t REL  = 2'd3;

  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_BSP = 4'hF;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Segments {dp,g,f,e,d,c,b,a}, active-low, dp off; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
  import keypad_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  assign seg = SEG_FONT[code];

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry stage: whole-scan debounce, one event per press, 4-digit hex edit buffer
// with clear/backspace/enter, and registered active-low HEX display drive.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned RELEASE_SCANS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        scan_done,
  output logic        key_event,
  output logic [3:0]  key_out,
  output logic [15:0] entry,
  output logic [2:0]  entry_len,
  output logic [15:0] value,
  output logic        value_strb,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3
);

  localparam logic [3:0] DebScans = DEBOUNCE_SCANS[3:0];
  localparam logic [3:0] RelScans = RELEASE_SCANS[3:0];

  // ---------------------------------------------------------------------------
  // Scan capture
  // ---------------------------------------------------------------------------
  logic       scan_hit_q;
  logic [3:0] scan_code_q;
  logic       hit;
  logic [3:0] cur_code;

  // A key_valid coinciding with scan_done is folded into the ending scan.
  assign hit      = scan_hit_q | key_valid;
  assign cur_code = key_valid ? key_code : scan_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_hit_q  <= 1'b0;
      scan_code_q <= 4'h0;
    end else if (scan_done) begin
      scan_hit_q  <= 1'b0;
      scan_code_q <= 4'h0;
    end else if (key_valid) begin
      scan_hit_q  <= 1'b1;
      scan_code_q <= key_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM, advanced once per completed scan
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_inc;
  logic       start_cand;
  logic       accept;
  logic       key_event_q, key_event_d;
  logic [3:0] key_out_q, key_out_d;

  assign cnt_inc = sat_inc(cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    start_cand = 1'b0;
    accept     = 1'b0;
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (hit) start_cand = 1'b1;
        end
        CAND: begin
          if (!hit) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cur_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebScans) accept = 1'b1;
          end else begin
            start_cand = 1'b1;
          end
        end
        HELD: begin
          if (!hit) begin
            if (RelScans <= 4'd1) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              state_d = REL;
              cnt_d   = 4'd1;
            end
          end else if (cur_code == cand_q) begin
            cnt_d = 4'd0;
          end else begin
            start_cand = 1'b1;
          end
        end
        REL: begin
          if (!hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= RelScans) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end
          end else if (cur_code == cand_q) begin
            // Bounce during release: resume holding without a new event.
            state_d = HELD;
            cnt_d   = 4'd0;
          end else begin
            start_cand = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      if (start_cand) begin
        cand_d = cur_code;
        if (DebScans <= 4'd1) begin
          accept = 1'b1;
        end else begin
          state_d = CAND;
          cnt_d   = 4'd1;
        end
      end

      if (accept) begin
        state_d = HELD;
        cnt_d   = 4'd0;
      end
    end
  end

  assign key_event_d = accept;
  assign key_out_d   = accept ? cur_code : key_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'h0;
      key_event_q <= 1'b0;
      key_out_q   <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_event_q <= key_event_d;
      key_out_q   <= key_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry editing
  // ---------------------------------------------------------------------------
  logic [15:0] entry_q, entry_d;
  logic [2:0]  entry_len_q, entry_len_d;
  logic [15:0] value_q, value_d;
  logic        value_strb_q, value_strb_d;

  always_comb begin
    entry_d      = entry_q;
    entry_len_d  = entry_len_q;
    value_d      = value_q;
    value_strb_d = 1'b0;
    if (key_event_q) begin
      case (key_out_q)
        KEY_CLR: begin
          entry_d     = 16'h0000;
          entry_len_d = 3'd0;
        end
        KEY_BSP: begin
          if (entry_len_q != 3'd0) begin
            entry_d     = {4'h0, entry_q[15:4]};
            entry_len_d = entry_len_q - 3'd1;
          end
        end
        KEY_ENT: begin
          if (entry_len_q != 3'd0) begin
            value_d      = entry_q;
            value_strb_d = 1'b1;
            entry_d      = 16'h0000;
            entry_len_d  = 3'd0;
          end
        end
        default: begin
          if (entry_len_q < 3'd4) begin
            entry_d     = {entry_q[11:0], key_out_q};
            entry_len_d = entry_len_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q      <= 16'h0000;
      entry_len_q  <= 3'd0;
      value_q      <= 16'h0000;
      value_strb_q <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      entry_len_q  <= entry_len_d;
      value_q      <= value_d;
      value_strb_q <= value_strb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------------
  logic [3:0][7:0] seg_raw;
  logic [3:0][7:0] hex_d;
  logic [3:0][7:0] hex_q;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    hex_to_7seg u_seg (
      .code (entry_q[4*i +: 4]),
      .seg  (seg_raw[i])
    );
    assign hex_d[i] = (3'(i) < entry_len_q) ? seg_raw[i] : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= {4{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign key_event  = key_event_q;
  assign key_out    = key_out_q;
  assign entry      = entry_q;
  assign entry_len  = entry_len_q;
  assign value      = value_q;
  assign value_strb = value_strb_q;
  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];

endmodule
